// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types for the decode->execute pipeline stage.
//   stage_state_t : occupancy-encoded stage state (EMPTY=0, BUSY=1, FULL=2)
//   dx_ctrl_t     : decode->execute control bundle; callers size CTRL_W
//                   as $bits(dx_ctrl_t)
//   DX_BUBBLE     : all-zero control word carried by an empty slot
package pipe_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic [1:0] imm_sel;
  } dx_ctrl_t;

  localparam int       DX_CTRL_W = $bits(dx_ctrl_t);
  localparam dx_ctrl_t DX_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- one payload register with load enable and clear.
//   clk   : clock
//   reset : asynchronous active-high reset, clears q
//   en    : load d into q
//   clr   : synchronous clear of q (wins over en)
//   d     : next payload
//   q     : held payload
module pipe_stage_reg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs -- valid/ready pipeline stage carrying a datapath payload
// and a decode->execute control payload, latency 1.
//   clk, reset         : clock, asynchronous active-high reset
//   flush              : synchronous kill of every held entry
//   in_valid/in_ready  : upstream handshake; in_data/in_ctrl payload
//   out_valid/out_ready: downstream handshake; out_data/out_ctrl payload
//   occupancy          : number of held entries (0..2)
// Build option: define PIPE_STAGE_SKID_EN for a two-entry stage (main +
// skid register, registered in_ready, full throughput). Without it the
// stage holds one entry and in_ready = !out_valid | out_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int                PW          = DATA_W + CTRL_W;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(DX_BUBBLE);

  stage_state_t    state_p1;
  logic            vld_p1;
  logic            in_fire;
  logic            out_fire;
  logic            main_en;
  logic            main_clr;
  logic [PW-1:0]   main_d;
  logic [PW-1:0]   main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic          in_ready_p1;
  logic          skid_en;
  logic          skid_clr;
  logic [PW-1:0] skid_q;

  // in_ready comes straight from a flop: no path from out_ready.
  assign in_ready = in_ready_p1;

  // Payload steering. FULL never sees in_fire because in_ready is low.
  always_comb begin
    main_en  = 1'b0;
    main_clr = flush;
    main_d   = {in_data, in_ctrl};
    skid_en  = 1'b0;
    skid_clr = flush;
    if (!flush) begin
      case (state_p1)
        ST_EMPTY: main_en = in_fire;
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
          end else if (out_fire) begin
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_en  = 1'b1;
            main_d   = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: main_clr = 1'b1;
      endcase
    end
  end

  // Stage FSM: state, out_valid and in_ready all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1    <= ST_EMPTY;
      vld_p1      <= 1'b0;
      in_ready_p1 <= 1'b1;
    end else if (flush) begin
      state_p1    <= ST_EMPTY;
      vld_p1      <= 1'b0;
      in_ready_p1 <= 1'b1;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (in_fire) begin
            state_p1 <= ST_BUSY;
            vld_p1   <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state_p1    <= ST_FULL;
            in_ready_p1 <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state_p1 <= ST_EMPTY;
            vld_p1   <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_p1    <= ST_BUSY;
            in_ready_p1 <= 1'b1;
          end
        end
        default: begin
          state_p1    <= ST_EMPTY;
          vld_p1      <= 1'b0;
          in_ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  // ---- skid register (second entry while downstream stalls) ----
  pipe_stage_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .clr   (skid_clr),
    .d     ({in_data, in_ctrl}),
    .q     (skid_q)
  );
`else
  // Single-entry stage: accept whenever the slot is empty or draining.
  assign in_ready = ~vld_p1 | out_ready;

  always_comb begin
    main_en  = 1'b0;
    main_clr = flush;
    main_d   = {in_data, in_ctrl};
    if (!flush) begin
      if (in_fire) begin
        main_en = 1'b1;
      end else if (out_fire) begin
        main_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= ST_EMPTY;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      state_p1 <= ST_EMPTY;
      vld_p1   <= 1'b0;
    end else if (in_fire) begin
      state_p1 <= ST_BUSY;
      vld_p1   <= 1'b1;
    end else if (out_fire) begin
      state_p1 <= ST_EMPTY;
      vld_p1   <= 1'b0;
    end
  end
`endif

  // ---- main register (entry presented downstream) ----
  pipe_stage_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .clr   (main_clr),
    .d     (main_d),
    .q     (main_q)
  );

  // Main register is cleared when it empties; the gating below makes the
  // bubble on an empty slot explicit.
  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? main_q[PW-1:CTRL_W] : '0;
  assign out_ctrl  = vld_p1 ? main_q[CTRL_W-1:0]  : BUBBLE_CTRL;
  assign occupancy = state_p1;

endmodule

// File: tb/tb_pipe_stage_hs.sv
`timescale 1ns/1ps
module tb_pipe_stage_hs;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int PW     = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0]     mq[$];   // model: held entries in acceptance order
  logic [DATA_W-1:0] got[$];  // payloads observed leaving the DUT
  bit                m_acc;
  bit                found;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
    return d[15:0] ^ 16'h5A3C;
  endfunction

  // A two-entry stage accepts while not full; a one-entry stage accepts
  // when empty or when its entry leaves this cycle.
  function automatic bit model_rdy();
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  // Behavioural model: a bounded FIFO updated on each clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      m_acc = in_valid && model_rdy();
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (m_acc) mq.push_back({in_data, in_ctrl});
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("out_data",  64'(out_data),  (mq.size() > 0) ? 64'(mq[0][PW-1:CTRL_W]) : 64'd0);
    chk("out_ctrl",  64'(out_ctrl),  (mq.size() > 0) ? 64'(mq[0][CTRL_W-1:0])  : 64'd0);
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("in_ready",  64'(in_ready),  64'(model_rdy()));
    if (out_valid && out_ready && !flush && !reset) got.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = v ? ctrl_of(d) : '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    step(); step();
    reset = 1'b0;

    // Single entry, latency 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h11);
    step();
    drive(1'b0, '0);
    #3;
    chk("lat1_out_valid", 64'(out_valid), 64'd1);
    chk("lat1_out_data",  64'(out_data),  64'h11);
    chk("lat1_out_ctrl",  64'(out_ctrl),  64'(ctrl_of(32'h11)));
    chk("lat1_occupancy", 64'(occupancy), 64'd1);
    step();

    // Back-to-back stream 1..8.
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    drive(1'b0, '0);
    step(); step(); step();
    chk("stream_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("stream_order", 64'(got[i]), 64'(i + 1));

    // Downstream stall with two pushes.
    got.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    drive(1'b1, 32'hB);
    @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
    chk("stall_rdy_busy", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, '0);
    @(negedge clk);
    chk("stall_occ_full", 64'(occupancy), 64'd2);
    chk("stall_rdy_full", 64'(in_ready),  64'd0);
    chk("stall_hold_a",   64'(out_data),  64'hA);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_first_a", 64'(out_data), 64'hA);
    step();
    @(negedge clk);
    chk("drain_then_b",   64'(out_data), 64'hB);
    chk("drain_rdy_back", 64'(in_ready), 64'd1);
    step();
`else
    chk("stall_rdy_busy", 64'(in_ready),  64'd0);
    chk("stall_occ_one",  64'(occupancy), 64'd1);
    chk("stall_hold_a",   64'(out_data),  64'hA);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_rdy_comb", 64'(in_ready), 64'd1);
    chk("drain_first_a",  64'(out_data), 64'hA);
    step();
    drive(1'b0, '0);
    @(negedge clk);
    chk("drain_then_b", 64'(out_data),  64'hB);
    chk("drain_occ",    64'(occupancy), 64'd1);
    step();
`endif
    step();
    chk("stall_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("stall_order0", 64'(got[0]), 64'hA);
      chk("stall_order1", 64'(got[1]), 64'hB);
    end

    // Flush with a simultaneous push.
    got.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'h21);
    step();
    drive(1'b1, 32'h22);
    step();
    drive(1'b0, '0);
    @(negedge clk);
    chk("preflush_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hC);
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    #3;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("flush_out_data",  64'(out_data),  64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    step(); step(); step();
    found = 1'b0;
    foreach (got[i]) if (got[i] == 32'hC) found = 1'b1;
    chk("flush_c_absent", 64'(found), 64'd0);
    chk("flush_nothing_out", 64'(got.size()), 64'd0);

    // Asynchronous reset while holding an entry.
    got.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'h5);
    step();
    drive(1'b0, '0);
    #2;
    chk("prerst_hold_5", 64'(out_data), 64'h5);
    reset = 1'b1;
    got.delete();
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_occ",   64'(occupancy), 64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h6);
    step();
    drive(1'b0, '0);
    step(); step();
    chk("postrst_count", 64'(got.size()), 64'd1);
    if (got.size() >= 1) chk("postrst_first", 64'(got[0]), 64'h6);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the datapath payload field.
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control payload field.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage accepts an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream datapath payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream accepts an entry this cycle.
REQ-012 out_data  output  DATA_W  downstream datapath payload.
REQ-013 out_ctrl  output  CTRL_W  downstream control payload.
REQ-014 occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 SHALL have latency 1: an entry accepted on edge N is presented on out_* after edge N when the stage was empty.
REQ-017 SHALL deliver entries in acceptance order, with none dropped or duplicated except by flush.
REQ-018 SHALL hold out_data/out_ctrl stable while out_valid=1 and out_ready=0.
REQ-019 SHALL drive out_ctrl to all-zero (bubble) whenever out_valid=0; out_data is then don't-care but SHALL be zero.
REQ-020 SHALL implement states EMPTY(occ 0), BUSY(occ 1, main reg), FULL(occ 2, main + skid reg).
REQ-021 In EMPTY, in_fire SHALL move to BUSY; otherwise stay.
REQ-022 In BUSY: in_fire & !out_fire -> FULL (new entry into skid); !in_fire & out_fire -> EMPTY; in_fire & out_fire -> BUSY, with the new entry replacing main; otherwise stay.
REQ-023 In FULL, out_fire SHALL move the skid entry to main and go to BUSY; in_fire is impossible.
REQ-024 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-025 flush=1 SHALL, at the next edge, force EMPTY, out_valid=0, and zero all held data and control.
REQ-026 flush=1 SHALL take priority over a simultaneous in_fire or out_fire; the incoming entry is discarded.
REQ-027 occupancy SHALL equal the state encoding and be registered.

Reset
REQ-028 reset SHALL immediately force EMPTY, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, and in_ready=1.
REQ-029 reset asserted mid-operation SHALL discard all held entries; the first in_fire after deassertion is the next entry delivered.

Configuration
REQ-030 With macro PIPE_STAGE_SKID_EN defined, the stage SHALL behave as REQ-020..REQ-024 (depth 2, full throughput, registered in_ready).
REQ-031 With PIPE_STAGE_SKID_EN undefined, the stage SHALL have no skid register and no FULL state.
REQ-032 In that case in_ready SHALL equal !out_valid | out_ready (combinational), and occupancy SHALL be at most 1.
REQ-033 All other requirements SHALL hold in both builds.

Structure
REQ-034 The state enum (EMPTY/BUSY/FULL) and the bubble constant (all-zero ctrl) SHALL live in shared package pipe_pkg.
REQ-035 The decode->execute control struct SHALL also live in pipe_pkg, so callers set CTRL_W to $bits of that struct.
REQ-036 A single sub-module, pipe_stage_reg (one enable-and-clear payload register, instantiated for main and skid), SHALL be used; no other hierarchy.

Verification
REQ-037 Reset then in_valid=1, in_data=0x11, out_ready=1 for one cycle -> out_valid=1, out_data=0x11 after 1 edge, occupancy=1.
REQ-038 Stream 0x1..0x8 back-to-back with out_ready=1 -> 8 consecutive out_fire cycles in order, in_ready never 0.
REQ-039 out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held; then out_ready=1 -> 0xA then 0xB, in_ready=1 after first pop (skid build); same stimulus in non-skid build -> in_ready=0 after 0xA, 0xB accepted only after 0xA leaves.
REQ-040 State FULL with flush=1 and in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears.
REQ-041 reset pulsed while BUSY holding 0x5 -> out_valid=0 before the next clk edge, and 0x5 never appears after deassertion.
